axi4_lite_m01: RTL

AXI4_LITE_M01 -- requirements
Module: axi4_lite_m01

---
 rtl/axil_m_pkg.sv | 19 +
 rtl/axil_m_timeout.sv | 30 +++
 rtl/axi4_lite_m01.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_m_pkg.sv
// Shared types and constants for the AXI4-Lite single-outstanding master.
package axil_m_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WAIT_B,
        ST_RD,
        ST_WAIT_R
    } state_t;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_DEAD;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_m_timeout.sv
// Per-transaction watchdog: clears on accept, counts busy cycles, flags expiry.
// Only instantiated when AXI4_LITE_M01_TIMEOUT_EN is defined.
module axil_m_timeout #(
    parameter int unsigned C_TIMEOUT_CYC = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_busy,
    output logic o_expired
);

    localparam int CW = $clog2(C_TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_busy) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Fires in the last allowed busy cycle so the abort lands right after it.
    assign o_expired = i_busy && (r_cnt == CW'(C_TIMEOUT_CYC - 1));

endmodule

// File: rtl/axi4_lite_m01.sv
// AXI4-Lite master: one command in, one register access out, one response back.
// Optional watchdog abort when AXI4_LITE_M01_TIMEOUT_EN is defined.
module axi4_lite_m01 #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 8,
    parameter int unsigned C_TIMEOUT_CYC      = 1023
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_rd,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [31:0]                   i_cmd_wdata,
    output logic                          o_rsp_valid,
    output logic [31:0]                   o_rsp_rdata,
    output logic                          o_rsp_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    import axil_m_pkg::*;

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [31:0]   r_wdata;
    logic [31:0]   w_wdata_nxt;
    logic          r_awvalid;
    logic          w_awvalid_nxt;
    logic          r_wvalid;
    logic          w_wvalid_nxt;
    logic          r_bready;
    logic          w_bready_nxt;
    logic          r_arvalid;
    logic          w_arvalid_nxt;
    logic          r_rready;
    logic          w_rready_nxt;
    logic          r_rsp_valid;
    logic          w_rsp_valid_nxt;
    logic          r_rsp_err;
    logic          w_rsp_err_nxt;
    logic [31:0]   r_rsp_rdata;
    logic [31:0]   w_rsp_rdata_nxt;
    logic          w_accept;
    logic          w_expired;

    assign o_cmd_ready = (r_state == ST_IDLE) && M_AXI_ARESETN;
    assign w_accept    = i_cmd_valid && o_cmd_ready;

`ifdef AXI4_LITE_M01_TIMEOUT_EN
    axil_m_timeout #(
        .C_TIMEOUT_CYC (C_TIMEOUT_CYC)
    ) u_timeout (
        .i_clk     (M_AXI_ACLK),
        .i_rst_n   (M_AXI_ARESETN),
        .i_clear   (w_accept),
        .i_busy    (r_state != ST_IDLE),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_addr_nxt  = i_cmd_addr & ALIGN_MASK;
                    w_wdata_nxt = i_cmd_wdata;
                    if (i_cmd_rd) begin
                        w_state_nxt   = ST_RD;
                        w_arvalid_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // AW and W retire independently; move on once both are gone.
                w_awvalid_nxt = r_awvalid && !M_AXI_AWREADY;
                w_wvalid_nxt  = r_wvalid && !M_AXI_WREADY;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_state_nxt  = ST_WAIT_B;
                    w_bready_nxt = 1'b1;
                end
            end
            ST_WAIT_B: begin
                if (M_AXI_BVALID) begin
                    w_state_nxt     = ST_IDLE;
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = resp_err(M_AXI_BRESP);
                    w_rsp_rdata_nxt = '0;
                end
            end
            ST_RD: begin
                if (M_AXI_ARREADY) begin
                    w_state_nxt   = ST_WAIT_R;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            ST_WAIT_R: begin
                if (M_AXI_RVALID) begin
                    w_state_nxt     = ST_IDLE;
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = resp_err(M_AXI_RRESP);
                    w_rsp_rdata_nxt = M_AXI_RDATA;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

`ifdef AXI4_LITE_M01_TIMEOUT_EN
        if (w_expired) begin
            w_state_nxt     = ST_IDLE;
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = TIMEOUT_FILL;
        end
`endif
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_rdata   = r_rsp_rdata;

endmodule
